// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter.
// Port A reads only; port B reads or writes with byte enables.
interface sram_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic [1:0]        b_be;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  modport master (
    output a_req, a_addr,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata, b_be,
    input  b_gnt, b_rvalid, b_rdata
  );

  modport slave (
    input  a_req, a_addr,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata, b_be,
    output b_gnt, b_rvalid, b_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for a 16-bit async SRAM.
// A (reads) has priority; B is forced in after MAX_A_STREAK A grants.
module sram_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 16,
  parameter int MAX_A_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  typedef enum logic [2:0] {
    IDLE, RD1, RD2, WR1, WR2, WR3, TURN
  } state_e;

  localparam int SW = $clog2(MAX_A_STREAK + 1);
  localparam logic [SW-1:0] S_MAX = SW'(MAX_A_STREAK);

  state_e            state, nxt;
  logic [SW-1:0]     streak;
  logic [1:0]        be_q, nxt_be;
  logic              src_b;
  logic              dq_oe;
  logic [DATA_W-1:0] dq_out;

  logic pick_a, pick_b, win_rd;
  logic gnt_a, gnt_b;
  logic nxt_rd, nxt_wr;
  logic ce_d, oe_d, we_d, dq_d;

  assign sram_dq = dq_oe ? dq_out : 'z;

  assign pick_a = bus.a_req && !(bus.b_req && streak == S_MAX);
  assign pick_b = bus.b_req && !pick_a;
  assign win_rd = pick_a || (pick_b && !bus.b_we);

  always_comb begin
    nxt   = state;
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    unique case (state)
      IDLE, RD2, WR3, TURN: begin
        // a read after a write waits one dead cycle, then re-arbitrates
        if (state == WR3 && win_rd) begin
          nxt = TURN;
        end else if (pick_a) begin
          nxt   = RD1;
          gnt_a = 1'b1;
        end else if (pick_b) begin
          nxt   = bus.b_we ? WR1 : RD1;
          gnt_b = 1'b1;
        end else begin
          nxt = IDLE;
        end
      end
      RD1:     nxt = RD2;
      WR1:     nxt = WR2;
      WR2:     nxt = WR3;
      default: nxt = IDLE;
    endcase
  end

  assign nxt_be = gnt_a ? 2'b11 :
                  gnt_b ? bus.b_be : be_q;
  assign nxt_rd = (nxt == RD1) || (nxt == RD2);
  assign nxt_wr = (nxt == WR1) || (nxt == WR2) || (nxt == WR3);

  always_comb begin
    ce_d = 1'b1;
    oe_d = 1'b1;
    we_d = 1'b1;
    dq_d = 1'b0;
    unique case (1'b1)
      nxt_rd: begin
        ce_d = 1'b0;
        oe_d = 1'b0;
      end
      nxt_wr: begin
        ce_d = 1'b0;
        we_d = (nxt != WR2);
        dq_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      streak       <= '0;
      be_q         <= 2'b00;
      src_b        <= 1'b0;
      dq_oe        <= 1'b0;
      dq_out       <= '0;
      sram_addr    <= '0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_ub_n    <= 1'b1;
      sram_lb_n    <= 1'b1;
      bus.a_gnt    <= 1'b0;
      bus.b_gnt    <= 1'b0;
      bus.a_rvalid <= 1'b0;
      bus.b_rvalid <= 1'b0;
      bus.a_rdata  <= '0;
      bus.b_rdata  <= '0;
    end else begin
      state     <= nxt;
      be_q      <= nxt_be;
      dq_oe     <= dq_d;
      sram_ce_n <= ce_d;
      sram_oe_n <= oe_d;
      sram_we_n <= we_d;
      sram_ub_n <= ce_d | ~nxt_be[1];
      sram_lb_n <= ce_d | ~nxt_be[0];
      bus.a_gnt <= gnt_a;
      bus.b_gnt <= gnt_b;
      if (gnt_a) begin
        src_b     <= 1'b0;
        sram_addr <= bus.a_addr;
      end
      if (gnt_b) begin
        src_b     <= 1'b1;
        sram_addr <= bus.b_addr;
        dq_out    <= bus.b_wdata;
      end
      if (!bus.b_req || gnt_b) begin
        streak <= '0;
      end else if (gnt_a && streak != S_MAX) begin
        streak <= streak + 1'b1;
      end
      bus.a_rvalid <= (state == RD2) && !src_b;
      bus.b_rvalid <= (state == RD2) && src_b;
      if (state == RD2 && !src_b) bus.a_rdata <= sram_dq;
      if (state == RD2 && src_b)  bus.b_rdata <= sram_dq;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: async SRAM model, shadow-memory scoreboard,
// directed timing steps and a randomized two-requester phase.
module tb_sram_arbiter;
  localparam int AW = 20;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_dq;
  logic ce_n, oe_n, we_n, ub_n, lb_n;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_A_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .sram_addr(sram_addr), .sram_dq(sram_dq),
    .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
    .sram_ub_n(ub_n), .sram_lb_n(lb_n)
  );

  int n_asserts = 0;
  int n_fail = 0;

  logic [15:0] mem    [0:(1<<20)-1];
  logic [15:0] shadow [0:(1<<20)-1];

  wire rd_en = !ce_n && !oe_n && we_n;
  assign sram_dq = rd_en ? mem[sram_addr] : 'z;

  always @(negedge clk) begin
    if (!ce_n && !we_n) begin
      if (!ub_n) mem[sram_addr][15:8] = sram_dq[15:8];
      if (!lb_n) mem[sram_addr][7:0]  = sram_dq[7:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] pick(input int r);
    return (r < 8) ? AW'(r) : 20'hFFFF0 + AW'(r);
  endfunction

  logic [15:0] qa[$];
  logic [15:0] qb[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end else begin
      if (bus.a_rvalid) begin
        chk("a_rvalid_expected", qa.size() != 0, 1);
        if (qa.size() != 0) chk("a_rdata", bus.a_rdata, qa.pop_front());
      end
      if (bus.b_rvalid) begin
        chk("b_rvalid_expected", qb.size() != 0, 1);
        if (qb.size() != 0) chk("b_rdata", bus.b_rdata, qb.pop_front());
      end
      if (bus.a_rvalid || bus.b_rvalid)
        chk("rvalid_excl", bus.a_rvalid & bus.b_rvalid, 0);
      if (bus.a_gnt) qa.push_back(shadow[bus.a_addr]);
      if (bus.b_gnt) begin
        if (bus.b_we) begin
          if (bus.b_be[1]) shadow[bus.b_addr][15:8] = bus.b_wdata[15:8];
          if (bus.b_be[0]) shadow[bus.b_addr][7:0]  = bus.b_wdata[7:0];
        end else begin
          qb.push_back(shadow[bus.b_addr]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] old;
    string seq;
    int gc[$];
    int bad, last, nrv;
    int aw, bw, maxw;
    bit ap, bp;

    bus.a_req = 0; bus.a_addr = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0;
    bus.b_wdata = '0; bus.b_be = 2'b00;
    for (int i = 0; i < (1 << 20); i++) begin
      mem[i] = 16'(i) ^ 16'h5A5A;
      shadow[i] = mem[i];
    end
    mem[20'h10] = 16'h1234;
    shadow[20'h10] = 16'h1234;

    @(negedge clk);
    chk("rst_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1F);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dq_oe", dut.dq_oe, 0);
    chk("rst_gnt_rv", {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid}, 0);
    chk("rst_rdata", {bus.a_rdata, bus.b_rdata}, 0);
    @(posedge clk); #2 rst_n = 1;
    repeat (2) @(negedge clk);
    chk("idle_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1F);

    // A read of 0x00010
    @(posedge clk); #2;
    bus.a_req = 1; bus.a_addr = 20'h10;
    @(negedge clk);
    chk("rd_pre_oe", oe_n, 1);
    chk("rd_pre_gnt", bus.a_gnt, 0);
    @(negedge clk);
    chk("rd1_gnt", bus.a_gnt, 1);
    chk("rd1_ce_oe", {ce_n, oe_n, we_n}, 3'b001);
    chk("rd1_lanes", {ub_n, lb_n}, 2'b00);
    chk("rd1_addr", sram_addr, 20'h10);
    @(posedge clk); #2 bus.a_req = 0;
    @(negedge clk);
    chk("rd2_gnt", bus.a_gnt, 0);
    chk("rd2_oe", oe_n, 0);
    chk("rd2_rvalid", bus.a_rvalid, 0);
    @(negedge clk);
    chk("rd_rvalid", bus.a_rvalid, 1);
    chk("rd_rdata", bus.a_rdata, 16'h1234);
    chk("rd_oe_off", oe_n, 1);
    @(negedge clk);
    chk("rd_rvalid_pulse", bus.a_rvalid, 0);
    chk("rd_rdata_hold", bus.a_rdata, 16'h1234);

    // B write 0xBEEF to 0x7FFFF, upper byte only
    old = mem[20'h7FFFF];
    @(posedge clk); #2;
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 20'h7FFFF;
    bus.b_wdata = 16'hBEEF; bus.b_be = 2'b10;
    @(negedge clk);
    @(negedge clk);
    chk("wr1_gnt", bus.b_gnt, 1);
    chk("wr1_strobes", {ce_n, oe_n, we_n}, 3'b011);
    chk("wr1_lanes", {ub_n, lb_n}, 2'b01);
    chk("wr1_dq", sram_dq, 16'hBEEF);
    @(posedge clk); #2 bus.b_req = 0;
    @(negedge clk);
    chk("wr2_we", we_n, 0);
    chk("wr2_gnt", bus.b_gnt, 0);
    @(negedge clk);
    chk("wr3_we", we_n, 1);
    chk("wr3_dq_hold", sram_dq, 16'hBEEF);
    chk("wr3_dq_oe", dut.dq_oe, 1);
    @(negedge clk);
    chk("wr_done_ce", ce_n, 1);
    chk("wr_done_dq_oe", dut.dq_oe, 0);
    chk("wr_mem_bytes", mem[20'h7FFFF], {8'hBE, old[7:0]});

    @(posedge clk); #2;
    bus.b_req = 1; bus.b_we = 0; bus.b_be = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("brd_gnt", bus.b_gnt, 1);
    @(posedge clk); #2 bus.b_req = 0;
    @(negedge clk);
    @(negedge clk);
    chk("brd_rvalid", bus.b_rvalid, 1);
    chk("brd_rdata", bus.b_rdata, {8'hBE, old[7:0]});

    // B write then A read: one turnaround cycle
    @(posedge clk); #2;
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 20'h2;
    bus.b_wdata = 16'h1357; bus.b_be = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("ta_wr_gnt", bus.b_gnt, 1);
    @(posedge clk); #2;
    bus.b_req = 0; bus.a_req = 1; bus.a_addr = 20'h2;
    @(negedge clk);
    chk("ta_wr2_we", we_n, 0);
    @(negedge clk);
    chk("ta_wr3_we", we_n, 1);
    @(negedge clk);
    chk("ta_turn_strobes", {ce_n, oe_n, we_n}, 3'b111);
    chk("ta_turn_dq_oe", dut.dq_oe, 0);
    chk("ta_turn_gnt", bus.a_gnt, 0);
    @(negedge clk);
    chk("ta_rd1_gnt", bus.a_gnt, 1);
    chk("ta_rd1_oe", oe_n, 0);
    @(posedge clk); #2 bus.a_req = 0;
    repeat (3) @(negedge clk);

    // reset during WR2
    @(posedge clk); #2;
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 20'h55555;
    bus.b_wdata = 16'hA5A5; bus.b_be = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("rw_gnt", bus.b_gnt, 1);
    @(posedge clk); #2 bus.b_req = 0;
    @(negedge clk);
    chk("rw_wr2_we", we_n, 0);
    #1 rst_n = 0;
    #1;
    chk("rw_async_we", we_n, 1);
    chk("rw_async_ce", ce_n, 1);
    chk("rw_async_dq_oe", dut.dq_oe, 0);
    @(posedge clk);
    @(posedge clk); #2 rst_n = 1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.a_gnt || bus.b_gnt || bus.a_rvalid || bus.b_rvalid) bad++;
    end
    chk("rw_quiet_after", bad, 0);
    chk("rw_strobes_after", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1F);

    // both held: A,A,A,A,B repeating with no gaps
    @(posedge clk); #2;
    bus.a_req = 1; bus.a_addr = 20'h5;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 20'h3; bus.b_be = 2'b11;
    seq = "";
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (bus.a_gnt) begin seq = {seq, "A"}; gc.push_back(c); end
      if (bus.b_gnt) begin seq = {seq, "B"}; gc.push_back(c); end
    end
    @(posedge clk); #2;
    bus.a_req = 0; bus.b_req = 0;
    chk("fair_count", seq.len() >= 10, 1);
    for (int k = 0; k < 10 && k < seq.len(); k++)
      chk($sformatf("fair_gnt%0d", k), seq[k], (k % 5 == 4) ? 8'h42 : 8'h41);
    bad = 0;
    for (int k = 1; k < 10 && k < gc.size(); k++)
      if (gc[k] - gc[k-1] != 2) bad++;
    chk("fair_no_gap", bad, 0);
    repeat (4) @(negedge clk);

    // alternating A reads, B idle
    @(posedge clk); #2;
    bus.a_req = 1; bus.a_addr = 20'h0;
    last = -1; nrv = 0; bad = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (bus.a_rvalid) begin
        if (last >= 0 && c - last != 2) bad++;
        last = c;
        nrv++;
      end
      if (bus.a_gnt) begin
        @(posedge clk); #2;
        bus.a_addr = (bus.a_addr == 20'h0) ? 20'hFFFFF : 20'h0;
      end
    end
    @(posedge clk); #2 bus.a_req = 0;
    chk("alt_rvalid_count", nrv >= 10, 1);
    chk("alt_rvalid_period", bad, 0);
    repeat (4) @(negedge clk);

    // randomized traffic on both ports
    ap = 0; bp = 0; aw = 0; bw = 0; maxw = 0;
    repeat (400) begin
      @(posedge clk); #2;
      if (!ap) begin
        if ($urandom_range(0, 3) != 0) begin
          bus.a_req = 1; bus.a_addr = pick($urandom_range(0, 15));
          ap = 1; aw = 0;
        end else bus.a_req = 0;
      end
      if (!bp) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.b_req = 1; bus.b_we = 1'($urandom_range(0, 1));
          bus.b_addr = pick($urandom_range(0, 15));
          bus.b_wdata = 16'($urandom); bus.b_be = 2'($urandom);
          bp = 1; bw = 0;
        end else bus.b_req = 0;
      end
      @(negedge clk);
      if (ap) begin if (bus.a_gnt) ap = 0; else aw++; end
      if (bp) begin if (bus.b_gnt) bp = 0; else bw++; end
      if (aw > maxw) maxw = aw;
      if (bw > maxw) maxw = bw;
    end
    @(posedge clk); #2;
    bus.a_req = 0; bus.b_req = 0;
    chk("rand_max_wait", maxw <= 20, 1);
    repeat (10) @(negedge clk);
    chk("rand_qa_empty", qa.size(), 0);
    chk("rand_qb_empty", qb.size(), 0);
    for (int r = 0; r < 16; r++)
      chk($sformatf("mem_%0h", pick(r)), mem[pick(r)], shadow[pick(r)]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule
